muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative signed multiply/divide engine plus its sequencing FSM. Replaces the combinational Mult/Div pair that feeds the HI/LO registers.
- The control unit issues a one-cycle start with an op select. The block runs one radix-2 iteration per cycle, applies sign correction, then pulses done.
- In the done cycle it presents hi/lo results, write enables for the HI/LO registers, and the overflow and divide-by-zero flags.

Parameters:
- WIDTH, 32, operand width; hi/lo are each WIDTH bits. The iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  1  0 = signed mult, 1 = signed div; sampled with start.
- a  in  WIDTH  multiplicand / dividend (A register value); sampled with start.
- b  in  WIDTH  multiplier / divisor (B register value); sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in the DONE state.
- hi  out  WIDTH  mult: product[2W-1:W]; div: remainder.
- lo  out  WIDTH  mult: product[W-1:0]; div: quotient.
- hi_write  out  1  equals done when no exception occurred; 0 on div-by-zero.
- lo_write  out  1  same rule as hi_write.
- mult_ovf  out  1  valid in DONE; high when hi is not the sign extension of lo[W-1].
- div_by_zero  out  1  valid in DONE; high when op=1 and b=0.

Behaviour:
- Reset: state=IDLE; busy, done, hi_write, lo_write, mult_ovf, div_by_zero = 0; hi = lo = 0; counter = 0.
- Reset asserted in any state (including mid-RUN) aborts the operation next edge. No done is issued.
- States: IDLE -> RUN -> FIX -> DONE -> IDLE.
- IDLE:
  - start=1 latches op, |a|, |b|, sign flags and counter=WIDTH.
  - If op=1 and b=0, go directly to DONE with div_by_zero=1; hi/lo are not changed.
  - Otherwise go to RUN.
- RUN: one iteration per cycle, counter decrements; leaves for FIX when counter reaches 1. Exactly WIDTH RUN cycles.
  - mult: unsigned shift-add on magnitudes with a 2W-bit accumulator.
  - div: restoring division on magnitudes with a W+1-bit partial remainder.
- FIX: apply signs and register hi/lo.
  - mult: product negated when the operand signs differ.
  - div: quotient negated when the signs differ; remainder takes the dividend's sign (truncation toward zero).
  - Compute mult_ovf.
- DONE: done=1 for exactly one cycle, with hi_write/lo_write per the rule above. Next state IDLE.
- Latency:
  - normal op: start edge t -> done high in cycle t+WIDTH+2.
  - divide-by-zero: done in cycle t+1.
- start outside IDLE (RUN, FIX, DONE) is ignored, not queued. start in the IDLE cycle following DONE is accepted.
- hi/lo, mult_ovf and div_by_zero hold until the next FIX or div-by-zero DONE.
- Arithmetic corner cases:
  - |-2^(W-1)| is the unsigned value 2^(W-1); no saturation.
  - (-2^(W-1)) / (-1): lo = 0x80000000, hi = 0, div_by_zero=0 (wrap, no flag).

Optional Feature:
- Macro MULDIV_ZERO_SKIP_EN.
- Defined: a mult with a=0 or b=0 skips RUN and FIX and goes IDLE -> DONE with hi = lo = 0, mult_ovf=0, hi_write = lo_write = 1. Latency 1 cycle.
- Undefined: every mult takes the full WIDTH+2 latency, with identical results.

Decomposition:
- Package muldiv_pkg holds:
  - state enum: IDLE, RUN, FIX, DONE.
  - op encodings: OP_MULT=1'b0, OP_DIV=1'b1.
  - default WIDTH constant.
- One natural sub-module, muldiv_step: purely combinational single iteration.
  - Inputs: op, accumulator/partial remainder, operand magnitude.
  - Outputs: next accumulator/remainder, next quotient bit.
- The FSM, counter and sign fix-up stay in muldiv_sequencer.

Test Plan:
- mult a=7, b=-3 (0xFFFFFFFD) -> done at t+34; hi=0xFFFFFFFF, lo=0xFFFFFFEB, mult_ovf=0, hi_write=lo_write=1.
- div a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_by_zero=0; done at t+34.
- div a=5, b=0 with previous hi/lo = 0x11/0x22 -> done at t+1, div_by_zero=1, hi_write=lo_write=0, hi/lo stay 0x11/0x22.
- mult a=b=0x80000000 -> hi=0x40000000, lo=0, mult_ovf=1; then div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- start re-pulsed at t+5 with different operands -> ignored, first result unchanged, single done. Separately, reset asserted at RUN cycle 10 -> IDLE next edge, all outputs 0, no done pulse.
- Zero operand: mult a=0, b=123. With MULDIV_ZERO_SKIP_EN -> done at t+1, hi=lo=0. Without -> done at t+34 with the same results.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on operand magnitudes.
//   mult: acc = {partial product, remaining multiplier bits}; add-then-shift right.
//   div : acc = {partial remainder, remaining dividend bits}; restoring step.
//         The new quotient bit is returned in q_bit; acc_nxt[0] is left clear
//         so the caller shifts it in.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 op,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     mag,
  output logic [2*WIDTH-1:0]   acc_nxt,
  output logic                 q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Single shift-add or restoring-subtract iteration
  always_comb begin
    sum     = '0;
    rem_sh  = '0;
    diff    = '0;
    acc_nxt = acc;
    q_bit   = 1'b0;
    if (op == OP_MULT) begin
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag} : {(WIDTH+1){1'b0}});
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end else begin
      // Remainder is always < mag <= 2^(W-1), so W+1 bits never overflow.
      rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff    = rem_sh - {1'b0, mag};
      q_bit   = ~diff[WIDTH];
      acc_nxt = {(q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide engine feeding the HI/LO registers.
// IDLE -> RUN (WIDTH cycles) -> FIX (sign correction) -> DONE (one-cycle pulse).
// Optional macro MULDIV_ZERO_SKIP_EN: a mult with a zero operand bypasses
// RUN/FIX and finishes in one cycle with a zero result.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             hi_write,
  output logic             lo_write,
  output logic             mult_ovf,
  output logic             div_by_zero
);

  state_e               state_q, state_d;
  logic                 op_q, op_d;
  logic                 neg_res_q, neg_res_d;   // operand signs differ
  logic                 neg_rem_q, neg_rem_d;   // dividend sign
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mag_q, mag_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 wr_q, wr_d;
  logic                 ovf_q, ovf_d;
  logic                 dz_q, dz_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   step_acc, prod;
  logic                 step_q;
  logic                 zero_skip;

  // Magnitudes; the most negative value maps to 2^(W-1) unsigned
  assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

`ifdef MULDIV_ZERO_SKIP_EN
  assign zero_skip = (op == OP_MULT) && ((a == '0) || (b == '0));
`else
  assign zero_skip = 1'b0;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .acc     (acc_q),
    .mag     (mag_q),
    .acc_nxt (step_acc),
    .q_bit   (step_q)
  );

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    mag_d     = mag_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    wr_d      = 1'b0;
    prod      = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          neg_res_d = a[WIDTH-1] ^ b[WIDTH-1];
          neg_rem_d = a[WIDTH-1];
          cnt_d     = CNT_W'(WIDTH);
          if (op == OP_MULT) begin
            acc_d = {{WIDTH{1'b0}}, b_mag};
            mag_d = a_mag;
          end else begin
            acc_d = {{WIDTH{1'b0}}, a_mag};
            mag_d = b_mag;
          end
          if ((op == OP_DIV) && (b == '0)) begin
            // hi/lo keep their previous contents; no register write
            state_d = DONE;
            done_d  = 1'b1;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
          end else if (zero_skip) begin
            state_d = DONE;
            done_d  = 1'b1;
            wr_d    = 1'b1;
            hi_d    = '0;
            lo_d    = '0;
            ovf_d   = 1'b0;
            dz_d    = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = {step_acc[2*WIDTH-1:1], step_acc[0] | step_q};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        if (op_q == OP_MULT) begin
          hi_d  = prod[2*WIDTH-1:WIDTH];
          lo_d  = prod[WIDTH-1:0];
          ovf_d = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
        end else begin
          // Truncating division: remainder follows the dividend's sign
          lo_d  = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
          hi_d  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
          ovf_d = 1'b0;
        end
        dz_d    = 1'b0;
        done_d  = 1'b1;
        wr_d    = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_MULT;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      mag_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      wr_q      <= 1'b0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      mag_q     <= mag_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      wr_q      <= wr_d;
      ovf_q     <= ovf_d;
      dz_q      <= dz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign hi_write    = wr_q;
  assign lo_write    = wr_q;
  assign mult_ovf    = ovf_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results are computed from
// 64-bit signed arithmetic when an op is issued and compared at done.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, hi_write, lo_write, mult_ovf, div_by_zero;
  logic [W-1:0] hi, lo;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .hi_write    (hi_write),
    .lo_write    (lo_write),
    .mult_ovf    (mult_ovf),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         ovf;
    logic         dz;
    logic         wr;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           passes = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: push the expected outcome of (o, x, y)
  task automatic push_exp(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint p, q, r;
    if (o == 1'b0) begin
      p     = longint'($signed(x)) * longint'($signed(y));
      e.hi  = p[63:32];
      e.lo  = p[31:0];
      e.ovf = (p[63:32] != {W{p[31]}});
      e.dz  = 1'b0;
      e.wr  = 1'b1;
      e.lat = W + 1;
`ifdef MULDIV_ZERO_SKIP_EN
      if (x == '0 || y == '0) e.lat = 0;
`endif
    end else if (y == '0) begin
      e.hi  = m_hi;
      e.lo  = m_lo;
      e.ovf = 1'b0;
      e.dz  = 1'b1;
      e.wr  = 1'b0;
      e.lat = 0;
    end else begin
      q     = longint'($signed(x)) / longint'($signed(y));
      r     = longint'($signed(x)) % longint'($signed(y));
      e.hi  = r[31:0];
      e.lo  = q[31:0];
      e.ovf = 1'b0;
      e.dz  = 1'b0;
      e.wr  = 1'b1;
      e.lat = W + 1;
    end
    m_hi = e.hi;
    m_lo = e.lo;
    sb.push_back(e);
  endtask

  // Drive a one-cycle start; returns #1 after the start edge
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    push_exp(o, x, y);
    tick();
    start = 1'b0;
  endtask

  // Edges after the start edge until done is seen (bounded)
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, hi, lo, hi_write, lo_write, mult_ovf, div_by_zero} !== '0)
      $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h wr=%b%b ovf=%b dz=%b want all zero",
               busy, done, hi, lo, hi_write, lo_write, mult_ovf, div_by_zero);
    else passes++;
  endtask

  task automatic test_mult();
    logic [W-1:0] xs[4];
    logic [W-1:0] ys[4];
    int lat;
    exp_t e;
    xs[0] = 32'd7;  ys[0] = 32'hFFFF_FFFD;
    xs[1] = $urandom(); ys[1] = $urandom();
    xs[2] = 32'h0001_2345; ys[2] = 32'h0000_0100;
    xs[3] = 32'hFFFF_FFFF; ys[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, xs[i], ys[i]);
      wait_done(lat);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) $display("FAIL mult_latency[%0d]: got %0d want %0d", i, lat, e.lat);
      else passes++;
      checks++;
      if ({hi, lo, mult_ovf, div_by_zero, hi_write, lo_write} !== {e.hi, e.lo, e.ovf, e.dz, e.wr, e.wr})
        $display("FAIL mult_result[%0d]: got hi=%h lo=%h ovf=%b dz=%b wr=%b%b want hi=%h lo=%h ovf=%b dz=%b wr=%b",
                 i, hi, lo, mult_ovf, div_by_zero, hi_write, lo_write, e.hi, e.lo, e.ovf, e.dz, e.wr);
      else passes++;
      tick();
    end
  endtask

  task automatic test_div();
    logic [W-1:0] xs[4];
    logic [W-1:0] ys[4];
    int lat;
    exp_t e;
    xs[0] = 32'hFFFF_FFF9; ys[0] = 32'd2;
    xs[1] = $urandom(); ys[1] = $urandom_range(1, 1000);
    xs[2] = $urandom(); ys[2] = $urandom() | 32'h8000_0001;
    xs[3] = 32'd3; ys[3] = 32'hFFFF_FFF9;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, xs[i], ys[i]);
      wait_done(lat);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, e.lat);
      else passes++;
      checks++;
      if ({hi, lo, mult_ovf, div_by_zero, hi_write, lo_write} !== {e.hi, e.lo, e.ovf, e.dz, e.wr, e.wr})
        $display("FAIL div_result[%0d]: got hi=%h lo=%h ovf=%b dz=%b wr=%b%b want hi=%h lo=%h ovf=%b dz=%b wr=%b",
                 i, hi, lo, mult_ovf, div_by_zero, hi_write, lo_write, e.hi, e.lo, e.ovf, e.dz, e.wr);
      else passes++;
      tick();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    exp_t e;
    // 0x2211 / 0x100 leaves hi=0x11, lo=0x22
    issue(1'b1, 32'h2211, 32'h100);
    wait_done(lat);
    e = sb.pop_front();
    tick();
    issue(1'b1, 32'd5, 32'd0);
    wait_done(lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) $display("FAIL divzero_latency: got %0d want %0d", lat, e.lat);
    else passes++;
    checks++;
    if ({hi, lo, div_by_zero, hi_write, lo_write} !== {e.hi, e.lo, e.dz, e.wr, e.wr})
      $display("FAIL divzero_result: got hi=%h lo=%h dz=%b wr=%b%b want hi=%h lo=%h dz=%b wr=%b",
               hi, lo, div_by_zero, hi_write, lo_write, e.hi, e.lo, e.dz, e.wr);
    else passes++;
    tick();
    checks++;
    if ({done, busy, hi, lo, div_by_zero} !== {1'b0, 1'b0, e.hi, e.lo, 1'b1})
      $display("FAIL divzero_hold: got done=%b busy=%b hi=%h lo=%h dz=%b want done=0 busy=0 hi=%h lo=%h dz=1",
               done, busy, hi, lo, div_by_zero, e.hi, e.lo);
    else passes++;
  endtask

  task automatic test_corner();
    int lat;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue(i[0], 32'h8000_0000, (i == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF);
      wait_done(lat);
      e = sb.pop_front();
      checks++;
      if ({lat == e.lat, hi, lo, mult_ovf, div_by_zero, hi_write} !== {1'b1, e.hi, e.lo, e.ovf, e.dz, e.wr})
        $display("FAIL corner[%0d]: got lat=%0d hi=%h lo=%h ovf=%b dz=%b wr=%b want lat=%0d hi=%h lo=%h ovf=%b dz=%b wr=%b",
                 i, lat, hi, lo, mult_ovf, div_by_zero, hi_write, e.lat, e.hi, e.lo, e.ovf, e.dz, e.wr);
      else passes++;
      tick();
    end
  endtask

  task automatic test_ignore_start();
    int   dones = 0;
    int   got_lat = -1;
    logic [W-1:0] ohi = '0, olo = '0;
    exp_t e;
    issue(1'b0, 32'd1234, 32'hFFFF_F000);
    for (int c = 1; c <= 45; c++) begin
      if (c == 5) begin start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7; end
      tick();
      start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        if (got_lat < 0) begin got_lat = c; ohi = hi; olo = lo; end
      end
    end
    e = sb.pop_front();
    checks++;
    if (dones !== 1 || got_lat !== e.lat)
      $display("FAIL ignore_start_done: got %0d pulses at %0d want 1 pulse at %0d", dones, got_lat, e.lat);
    else passes++;
    checks++;
    if ({ohi, olo} !== {e.hi, e.lo})
      $display("FAIL ignore_start_result: got hi=%h lo=%h want hi=%h lo=%h", ohi, olo, e.hi, e.lo);
    else passes++;
  endtask

  task automatic test_reset_mid_run();
    int dones = 0;
    exp_t e;
    issue(1'b0, 32'd99, 32'd77);
    e = sb.pop_back();   // aborted op never completes
    for (int c = 1; c < 10; c++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({busy, done, hi, lo, hi_write, lo_write, mult_ovf, div_by_zero} !== '0)
      $display("FAIL reset_mid_run: got busy=%b done=%b hi=%h lo=%h wr=%b%b ovf=%b dz=%b want all zero",
               busy, done, hi, lo, hi_write, lo_write, mult_ovf, div_by_zero);
    else passes++;
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0 || busy !== 1'b0)
      $display("FAIL reset_no_done: got %0d pulses busy=%b want 0 pulses busy=0", dones, busy);
    else passes++;
  endtask

  task automatic test_zero_operand();
    int lat;
    exp_t e;
    issue(1'b0, 32'd0, 32'd123);
    wait_done(lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) $display("FAIL zero_op_latency: got %0d want %0d", lat, e.lat);
    else passes++;
    checks++;
    if ({hi, lo, mult_ovf, hi_write, lo_write} !== {e.hi, e.lo, e.ovf, e.wr, e.wr})
      $display("FAIL zero_op_result: got hi=%h lo=%h ovf=%b wr=%b%b want hi=%h lo=%h ovf=%b wr=%b",
               hi, lo, mult_ovf, hi_write, lo_write, e.hi, e.lo, e.ovf, e.wr);
    else passes++;
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(i[0], $urandom(), $urandom() | 32'h1);
      wait_done(lat);
      e = sb.pop_front();
      checks++;
      if ({lat == e.lat, hi, lo, mult_ovf, div_by_zero, hi_write} !== {1'b1, e.hi, e.lo, e.ovf, e.dz, e.wr})
        $display("FAIL b2b[%0d]: got lat=%0d hi=%h lo=%h ovf=%b dz=%b wr=%b want lat=%0d hi=%h lo=%h ovf=%b dz=%b wr=%b",
                 i, lat, hi, lo, mult_ovf, div_by_zero, hi_write, e.lat, e.hi, e.lo, e.ovf, e.dz, e.wr);
      else passes++;
      tick();
      // Next op starts in the IDLE cycle right after DONE
      checks++;
      if ({done, busy} !== 2'b00) $display("FAIL b2b_idle[%0d]: got done=%b busy=%b want 0 0", i, done, busy);
      else passes++;
    end
  endtask

  initial begin
    for (int c = 0; c < 3; c++) tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_mult();
    test_div();
    test_div_zero();
    test_corner();
    test_ignore_start();
    test_reset_mid_run();
    test_zero_operand();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
